// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin selection of one of three result producers per cycle
// into the register-file write port, plus a busy-bit scoreboard for RAW hazard detection.
module writeback_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  reqValid,
   input  logic [4:0]  reqReg0,
   input  logic [4:0]  reqReg1,
   input  logic [4:0]  reqReg2,
   input  logic [31:0] reqData0,
   input  logic [31:0] reqData1,
   input  logic [31:0] reqData2,
   output logic [2:0]  reqReady,
   input  logic        issueValid,
   input  logic [4:0]  issueReg,
   input  logic [4:0]  readRegister1,
   input  logic [4:0]  readRegister2,
   output logic        hazard1,
   output logic        hazard2,
   output logic [4:0]  writeRegister,
   output logic [31:0] writeData,
   output logic        regWrite
);

   logic [1:0]  pointer;
   logic [1:0]  nextPointer;
   logic [2:0]  rotValid;
   logic [2:0]  rotGrant;
   logic        transfer;
   logic [4:0]  winReg;
   logic [31:0] winData;
   logic [31:0] busy;
   logic [31:0] busyNext;

   // Rotate requests so the current highest-priority requester sits at bit 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      rotValid = reqValid;
      case (pointer)
         2'd1:    rotValid = {reqValid[0], reqValid[2:1]};
         2'd2:    rotValid = {reqValid[1:0], reqValid[2]};
         default: rotValid = reqValid;
      endcase

      rotGrant = 3'b000;
      if (rotValid[0])      rotGrant = 3'b001;
      else if (rotValid[1]) rotGrant = 3'b010;
      else if (rotValid[2]) rotGrant = 3'b100;

      reqReady = 3'b000;
      if (rst) begin
         case (pointer)
            2'd1:    reqReady = {rotGrant[1:0], rotGrant[2]};
            2'd2:    reqReady = {rotGrant[0], rotGrant[2:1]};
            default: reqReady = rotGrant;
         endcase
      end
   end

   // reqReady already implies reqValid, so any set bit is a transfer.
   always_comb begin
      transfer    = |reqReady;
      winReg      = 5'd0;
      winData     = 32'd0;
      nextPointer = pointer;
      if (reqReady[0]) begin
         winReg      = reqReg0;
         winData     = reqData0;
         nextPointer = 2'd1;
      end else if (reqReady[1]) begin
         winReg      = reqReg1;
         winData     = reqData1;
         nextPointer = 2'd2;
      end else if (reqReady[2]) begin
         winReg      = reqReg2;
         winData     = reqData2;
         nextPointer = 2'd0;
      end
   end

   // Set is applied after clear: a newly issued producer outranks a retiring one.
   always_comb begin
      busyNext = busy;
      if (transfer)
         busyNext[winReg] = 1'b0;
      if (issueValid && (issueReg != 5'd0))
         busyNext[issueReg] = 1'b1;
      busyNext[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pointer       <= 2'd0;
         busy          <= 32'd0;
         regWrite      <= 1'b0;
         writeRegister <= 5'd0;
         writeData     <= 32'd0;
      end else begin
         pointer  <= nextPointer;
         busy     <= busyNext;
         regWrite <= transfer && (winReg != 5'd0);
         if (transfer) begin
            writeRegister <= winReg;
            writeData     <= winData;
         end
      end
   end

   // The write in flight has already cleared its busy bit, so it is checked separately.
   always_comb begin
      hazard1 = busy[readRegister1] ||
                (regWrite && (writeRegister == readRegister1) && (readRegister1 != 5'd0));
      hazard2 = busy[readRegister2] ||
                (regWrite && (writeRegister == readRegister2) && (readRegister2 != 5'd0));
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter: inputs driven on the falling edge,
// outputs compared 1 time unit later against hand-computed values.
module tb_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  reqValid;
   logic [4:0]  reqReg0, reqReg1, reqReg2;
   logic [31:0] reqData0, reqData1, reqData2;
   logic [2:0]  reqReady;
   logic        issueValid;
   logic [4:0]  issueReg;
   logic [4:0]  readRegister1, readRegister2;
   logic        hazard1, hazard2;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic        regWrite;

   int checks;
   int failures;

   writeback_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .reqValid      (reqValid),
      .reqReg0       (reqReg0),
      .reqReg1       (reqReg1),
      .reqReg2       (reqReg2),
      .reqData0      (reqData0),
      .reqData1      (reqData1),
      .reqData2      (reqData2),
      .reqReady      (reqReady),
      .issueValid    (issueValid),
      .issueReg      (issueReg),
      .readRegister1 (readRegister1),
      .readRegister2 (readRegister2),
      .hazard1       (hazard1),
      .hazard2       (hazard2),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .regWrite      (regWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Wait for the falling edge; callers drive inputs there and compare after #1.
   task automatic nextCycle();
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset state, with requests and an issue already present
      rst           = 1'b0;
      reqValid      = 3'b111;
      reqReg0       = 5'd1;  reqData0 = 32'h11;
      reqReg1       = 5'd2;  reqData1 = 32'h22;
      reqReg2       = 5'd3;  reqData2 = 32'h33;
      issueValid    = 1'b1;
      issueReg      = 5'd4;
      readRegister1 = 5'd4;
      readRegister2 = 5'd1;
      #1;
      check("rst_ready", reqReady, 3'b000);
      check("rst_regwrite", regWrite, 1'b0);
      check("rst_wreg", writeRegister, 5'd0);
      check("rst_wdata", writeData, 32'd0);
      check("rst_haz1", hazard1, 1'b0);
      nextCycle();
      nextCycle();
      check("rst_held_ready", reqReady, 3'b000);
      check("rst_held_haz1", hazard1, 1'b0);
      issueValid = 1'b0;
      reqValid   = 3'b000;
      rst        = 1'b1;
      #1;
      check("rel_regwrite", regWrite, 1'b0);

      // Round-robin over three requesters: 001, 010, 100
      nextCycle();
      reqValid = 3'b111;
      #1;
      check("rr_grant0", reqReady, 3'b001);
      nextCycle();
      #1;
      check("rr_grant1", reqReady, 3'b010);
      check("rr_wr0_en", regWrite, 1'b1);
      check("rr_wr0_reg", writeRegister, 5'd1);
      check("rr_wr0_data", writeData, 32'h11);
      check("rr_inflight_haz2", hazard2, 1'b1);
      nextCycle();
      #1;
      check("rr_grant2", reqReady, 3'b100);
      check("rr_wr1_reg", writeRegister, 5'd2);
      check("rr_wr1_data", writeData, 32'h22);
      nextCycle();
      reqValid = 3'b000;
      #1;
      check("rr_idle_ready", reqReady, 3'b000);
      check("rr_wr2_en", regWrite, 1'b1);
      check("rr_wr2_reg", writeRegister, 5'd3);
      check("rr_wr2_data", writeData, 32'h33);
      nextCycle();
      #1;
      check("idle_regwrite", regWrite, 1'b0);
      check("idle_hold_reg", writeRegister, 5'd3);
      check("idle_hold_data", writeData, 32'h33);

      // Issue r5, then the load producer retires it (pointer is 0)
      nextCycle();
      issueValid    = 1'b1;
      issueReg      = 5'd5;
      readRegister1 = 5'd5;
      #1;
      check("r5_pre_issue_haz", hazard1, 1'b0);
      nextCycle();
      issueValid = 1'b0;
      reqValid   = 3'b010;
      reqReg1    = 5'd5;
      reqData1   = 32'hDEADBEEF;
      #1;
      check("r5_busy_haz", hazard1, 1'b1);
      check("r5_grant", reqReady, 3'b010);
      nextCycle();
      reqValid = 3'b000;
      #1;
      check("r5_inflight_haz", hazard1, 1'b1);
      check("r5_wr_en", regWrite, 1'b1);
      check("r5_wr_reg", writeRegister, 5'd5);
      check("r5_wr_data", writeData, 32'hDEADBEEF);
      nextCycle();
      #1;
      check("r5_clear_haz", hazard1, 1'b0);
      check("r5_after_regwrite", regWrite, 1'b0);

      // ALU write to r0 is accepted but never written (pointer is 2)
      nextCycle();
      reqValid      = 3'b001;
      reqReg0       = 5'd0;
      reqData0      = 32'h1234;
      readRegister2 = 5'd0;
      #1;
      check("r0_grant", reqReady, 3'b001);
      nextCycle();
      reqValid = 3'b000;
      #1;
      check("r0_regwrite", regWrite, 1'b0);
      check("r0_haz2", hazard2, 1'b0);

      // Issue r7 together with a retiring write to r7 (pointer is 1): set wins
      nextCycle();
      issueValid    = 1'b1;
      issueReg      = 5'd7;
      reqValid      = 3'b100;
      reqReg2       = 5'd7;
      reqData2      = 32'h77;
      readRegister2 = 5'd7;
      #1;
      check("r7_grant", reqReady, 3'b100);
      nextCycle();
      issueValid = 1'b0;
      reqValid   = 3'b000;
      #1;
      check("r7_wr_en", regWrite, 1'b1);
      check("r7_haz2_inflight", hazard2, 1'b1);
      nextCycle();
      #1;
      check("r7_regwrite_off", regWrite, 1'b0);
      check("r7_busy_kept", hazard2, 1'b1);

      // Reset mid-flight after a write to r3 (pointer is 0)
      nextCycle();
      reqValid      = 3'b001;
      reqReg0       = 5'd3;
      reqData0      = 32'h3333;
      readRegister1 = 5'd7;
      #1;
      check("r3_grant", reqReady, 3'b001);
      nextCycle();
      reqValid = 3'b000;
      #1;
      check("r3_wr_en", regWrite, 1'b1);
      check("r3_wr_reg", writeRegister, 5'd3);
      #1;
      rst = 1'b0;
      #1;
      check("arst_regwrite", regWrite, 1'b0);
      check("arst_wreg", writeRegister, 5'd0);
      check("arst_wdata", writeData, 32'd0);
      check("arst_busy7", hazard1, 1'b0);
      nextCycle();
      rst      = 1'b1;
      reqValid = 3'b111;
      reqReg0  = 5'd9;
      reqData0 = 32'h99;
      #1;
      check("arst_rel_regwrite", regWrite, 1'b0);
      check("arst_ptr0_grant", reqReady, 3'b001);
      nextCycle();
      reqValid = 3'b000;
      #1;
      check("arst_first_wr_reg", writeRegister, 5'd9);
      check("arst_first_wr_data", writeData, 32'h99);

      // Only requester 2 for four cycles (pointer starts at 1, then wraps to 0)
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         reqValid = 3'b100;
         reqReg2  = 5'd10;
         reqData2 = 32'hA0 + 32'(i);
         #1;
         check($sformatf("solo2_grant%0d", i), reqReady, 3'b100);
         if (i > 0)
            check($sformatf("solo2_data%0d", i - 1), writeData, 32'hA0 + 32'(i - 1));
      end
      nextCycle();
      reqValid = 3'b111;
      #1;
      check("solo2_last_data", writeData, 32'hA3);
      check("solo2_wrap_grant", reqReady, 3'b001);
      nextCycle();
      reqValid = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
